// File: rtl/shared_not_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// shared_not_arbiter_pkg
// Shared definitions for the shared NOT-stage arbiter:
//   - state encoding of the sequencing FSM
//   - default requester count and completed-operation counter width
//   - ptr_width(): width of a requester index for a given requester count
// ---------------------------------------------------------------------------
package shared_not_arbiter_pkg;

    localparam int DEF_N     = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SERVE = 2'b01,
        DONE  = 2'b10
    } state_t;

    // A single requester still needs a 1-bit pointer, so clamp at 1.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_not_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// shared_not_arbiter_rr_pick
// Combinational round-robin winner selection. Scans req starting at ptr,
// wrapping modulo N, and reports the first requester found.
//
// Ports:
//   req    in  [N-1:0]      request vector
//   ptr    in  [PTR_W-1:0]  index holding highest priority this round
//   winner out [PTR_W-1:0]  selected requester (0 when none found)
//   found  out              at least one request is pending
// ---------------------------------------------------------------------------
module shared_not_arbiter_rr_pick
    import shared_not_arbiter_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic             found
);

    int               idx;
    logic [PTR_W-1:0] idx_v;

    // Walk the offsets from farthest to nearest so that the nearest pending
    // request (lowest offset from ptr) is the last one written and wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        idx_v  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx   = (int'(ptr) + k) % N;
            idx_v = PTR_W'(idx);
            if (req[idx_v]) begin
                winner = idx_v;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_not_arbiter.sv
// ---------------------------------------------------------------------------
// shared_not_arbiter
// Round-robin arbiter and sequencer that shares one gate-level NOT stage
// among N requesters. A granted requester's operand is latched, inverted
// through the NOT primitive, and returned with a one-hot acknowledge.
//
// Ports:
//   clk       in             system clock, rising edge
//   rst       in             synchronous active-high reset
//   req       in  [N-1:0]    per-requester request, held until its ack
//   din       in  [N-1:0]    per-requester operand, sampled at grant
//   grant     out [N-1:0]    one-hot, registered, held through the service
//   ack       out [N-1:0]    one-hot, one-cycle result-valid pulse
//   dout      out            inverted operand, valid while ack is non-zero
//   busy      out            FSM is not IDLE
//   op_count  out [CNT_W-1:0] completed operations, wrapping
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no service; winner picked from req, grant/operand load on exit
// SERVE | operand passes through the NOT stage into the result register
// DONE  | ack and dout presented; counter and pointer advance on exit
// ---------------------------------------------------------------------------
module shared_not_arbiter
    import shared_not_arbiter_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     din,
    output logic [N-1:0]     grant,
    output logic [N-1:0]     ack,
    output logic             dout,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int PTR_W = ptr_width(N);

    state_t           state;
    state_t           state_nxt;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win_q;
    logic [PTR_W-1:0] pick;
    logic             found;
    logic [N-1:0]     pick_onehot;
    logic             operand;
    logic             result;
    wire              not_out;

    shared_not_arbiter_rr_pick #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick),
        .found  (found)
    );

    // The single shared inverter every requester is time-multiplexed onto.
    not u_not (not_out, operand);

    assign pick_onehot = N'(1) << pick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            ptr      <= '0;
            win_q    <= '0;
            operand  <= 1'b0;
            result   <= 1'b0;
            op_count <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant   <= pick_onehot;
                        win_q   <= pick;
                        operand <= din[pick];
                    end
                end
                SERVE: begin
                    result <= not_out;
                end
                DONE: begin
                    grant    <= '0;
                    op_count <= op_count + CNT_W'(1);
                    // The served requester drops to lowest priority.
                    ptr      <= (win_q == PTR_W'(N - 1)) ? '0 : win_q + PTR_W'(1);
                end
                default: begin
                    grant <= '0;
                end
            endcase
        end
    end

    // ack/dout are decoded from registered state and registered grant/result,
    // so they are clean one-cycle pulses aligned with DONE.
    always_comb begin
        state_nxt = state;
        ack       = '0;
        dout      = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (found) begin
                    state_nxt = SERVE;
                end
            end
            SERVE: begin
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
                ack       = grant;
                dout      = result;
            end
            default: begin
                state_nxt = IDLE;
                busy      = 1'b0;
            end
        endcase
    end

endmodule
